// File: rtl/psg_multi.sv
// psg_multi: NUM_CH square-wave tone channels, one shared 17-bit LFSR noise source, one 16-step envelope.
// Macro PSG_READBACK_EN adds the DO register readback mux; without it DO is constant 8'hFF.
module psg_multi #(
    parameter int NUM_CH = 3,
    parameter int DAC_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CE,
    input  logic                    WR,
    input  logic [ADDR_W-1:0]       ADDR,
    input  logic [7:0]              DI,
    output logic [7:0]              DO,
    output logic [NUM_CH*DAC_W-1:0] CH_OUT,
    output logic [DAC_W+2:0]        MIX
);
    localparam int T     = 2 * NUM_CH;
    localparam int V     = T + 3;
    localparam int E     = V + NUM_CH;
    localparam int REP   = (DAC_W + 7) / 8;
    localparam int MIX_W = DAC_W + 3;

    logic [11:0]       tper_q [NUM_CH];
    logic [4:0]        vol_q  [NUM_CH];
    logic [4:0]        nper_q;
    logic [NUM_CH-1:0] tdis_q;
    logic [NUM_CH-1:0] ndis_q;
    logic [15:0]       eper_q;
    logic [3:0]        shape_q;
    logic              shape_wr;

    assign shape_wr = WR && (ADDR == ADDR_W'(E + 2));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tper_q[c] <= '0;
                vol_q[c]  <= '0;
            end
            nper_q  <= '0;
            tdis_q  <= '0;
            ndis_q  <= '0;
            eper_q  <= '0;
            shape_q <= '0;
        end else if (WR) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ADDR == ADDR_W'(2 * c))     tper_q[c][7:0]  <= DI;
                if (ADDR == ADDR_W'(2 * c + 1)) tper_q[c][11:8] <= DI[3:0];
                if (ADDR == ADDR_W'(V + c))     vol_q[c]        <= DI[4:0];
            end
            if (ADDR == ADDR_W'(T))     nper_q       <= DI[4:0];
            if (ADDR == ADDR_W'(T + 1)) tdis_q       <= DI[NUM_CH-1:0];
            if (ADDR == ADDR_W'(T + 2)) ndis_q       <= DI[NUM_CH-1:0];
            if (ADDR == ADDR_W'(E))     eper_q[7:0]  <= DI;
            if (ADDR == ADDR_W'(E + 1)) eper_q[15:8] <= DI;
            if (shape_wr)               shape_q      <= DI[3:0];
        end
    end

    // Prescaler: tone tick every 8 CE, envelope tick every 16 CE.
    logic [3:0] presc_q;
    logic [3:0] presc_d;
    logic       tone_tick;
    logic       env_tick;

    assign presc_d   = CE ? presc_q - 4'd1 : presc_q;
    assign tone_tick = CE && (presc_q[2:0] == 3'd0);
    assign env_tick  = CE && (presc_q == 4'd0);

    logic [11:0]       tcnt_q [NUM_CH];
    logic [11:0]       tcnt_d [NUM_CH];
    logic [NUM_CH-1:0] tone_q;
    logic [NUM_CH-1:0] tone_d;

    // A period written below the running count wraps on the very next tick.
    always_comb begin
        tone_d = tone_q;
        for (int c = 0; c < NUM_CH; c++) begin
            tcnt_d[c] = tcnt_q[c];
            if (tone_tick) begin
                if (tcnt_q[c] >= ((tper_q[c] == 12'd0) ? 12'd0 : tper_q[c] - 12'd1)) begin
                    tcnt_d[c] = '0;
                    tone_d[c] = ~tone_q[c];
                end else begin
                    tcnt_d[c] = tcnt_q[c] + 12'd1;
                end
            end
        end
    end

    logic [4:0]  ncnt_q;
    logic [4:0]  ncnt_d;
    logic [16:0] lfsr_q;
    logic [16:0] lfsr_d;

    always_comb begin
        ncnt_d = ncnt_q;
        lfsr_d = lfsr_q;
        if (tone_tick) begin
            if (ncnt_q >= ((nper_q == 5'd0) ? 5'd0 : nper_q - 5'd1)) begin
                ncnt_d = '0;
                lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                ncnt_d = ncnt_q + 5'd1;
            end
        end
    end

    logic [15:0] ecnt_q;
    logic [15:0] ecnt_d;
    logic [15:0] elim;
    logic [3:0]  step_q;
    logic [3:0]  step_d;
    logic [3:0]  elvl_q;
    logic [3:0]  elvl_d;
    logic [3:0]  lvl_now;
    logic        att_q;
    logic        att_d;
    logic        hold_q;
    logic        hold_d;

    assign elim = (eper_q == 16'd0) ? 16'd0 : eper_q - 16'd1;

    // att_q is the direction of the current cycle; it flips per cycle for ALT shapes.
    always_comb begin
        lvl_now = att_q ? step_q : 4'd15 - step_q;
        if (hold_q) lvl_now = (shape_q[3] && (shape_q[2] ^ shape_q[1])) ? 4'd15 : 4'd0;
    end

    // A shape write overrides any envelope tick landing on the same CLK.
    always_comb begin
        ecnt_d = ecnt_q;
        step_d = step_q;
        elvl_d = elvl_q;
        att_d  = att_q;
        hold_d = hold_q;
        if (shape_wr) begin
            ecnt_d = '0;
            step_d = '0;
            att_d  = DI[2];
            hold_d = 1'b0;
        end else if (env_tick) begin
            elvl_d = lvl_now;
            if (ecnt_q >= elim) begin
                ecnt_d = '0;
                if (!hold_q) begin
                    if (step_q == 4'd15) begin
                        if (!shape_q[3] || shape_q[0]) begin
                            hold_d = 1'b1;
                        end else begin
                            step_d = '0;
                            if (shape_q[1]) att_d = ~att_q;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end else begin
                ecnt_d = ecnt_q + 16'd1;
            end
        end
    end

    function automatic logic [7:0] vol_table(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'd0;
            4'd1:    return 8'd1;
            4'd2:    return 8'd2;
            4'd3:    return 8'd3;
            4'd4:    return 8'd5;
            4'd5:    return 8'd7;
            4'd6:    return 8'd11;
            4'd7:    return 8'd15;
            4'd8:    return 8'd22;
            4'd9:    return 8'd31;
            4'd10:   return 8'd45;
            4'd11:   return 8'd63;
            4'd12:   return 8'd90;
            4'd13:   return 8'd127;
            4'd14:   return 8'd180;
            default: return 8'd255;
        endcase
    endfunction

    // Widen by repeating the 8-bit level MSB-first, so full scale stays all ones.
    function automatic logic [DAC_W-1:0] widen(input logic [7:0] v);
        logic [8*REP-1:0] rep;
        rep = {REP{v}};
        return rep[8*REP-1 -: DAC_W];
    endfunction

    logic [NUM_CH-1:0]       gate;
    logic [NUM_CH*DAC_W-1:0] ch_q;
    logic [NUM_CH*DAC_W-1:0] ch_d;
    logic [MIX_W-1:0]        mix_q;
    logic [MIX_W-1:0]        mix_d;

    assign gate = (tdis_q | tone_q) & (ndis_q | {NUM_CH{lfsr_q[0]}});

    always_comb begin
        ch_d  = ch_q;
        mix_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CE) begin
                ch_d[c*DAC_W +: DAC_W] = gate[c] ?
                    widen(vol_table(vol_q[c][4] ? elvl_q : vol_q[c][3:0])) : '0;
            end
            mix_d = mix_d + MIX_W'(ch_q[c*DAC_W +: DAC_W]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
            tone_q  <= '0;
            ncnt_q  <= '0;
            lfsr_q  <= 17'h00001;
            ecnt_q  <= '0;
            step_q  <= '0;
            elvl_q  <= '0;
            att_q   <= 1'b0;
            hold_q  <= 1'b0;
            ch_q    <= '0;
            mix_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) tcnt_q[c] <= '0;
        end else begin
            presc_q <= presc_d;
            tone_q  <= tone_d;
            ncnt_q  <= ncnt_d;
            lfsr_q  <= lfsr_d;
            ecnt_q  <= ecnt_d;
            step_q  <= step_d;
            elvl_q  <= elvl_d;
            att_q   <= att_d;
            hold_q  <= hold_d;
            ch_q    <= ch_d;
            mix_q   <= mix_d;
            for (int c = 0; c < NUM_CH; c++) tcnt_q[c] <= tcnt_d[c];
        end
    end

    assign CH_OUT = ch_q;
    assign MIX    = mix_q;

`ifdef PSG_READBACK_EN
    always_comb begin
        DO = 8'hFF;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ADDR == ADDR_W'(2 * c))     DO = tper_q[c][7:0];
            if (ADDR == ADDR_W'(2 * c + 1)) DO = {4'h0, tper_q[c][11:8]};
            if (ADDR == ADDR_W'(V + c))     DO = {3'h0, vol_q[c]};
        end
        if (ADDR == ADDR_W'(T))     DO = {3'h0, nper_q};
        if (ADDR == ADDR_W'(T + 1)) DO = 8'(tdis_q);
        if (ADDR == ADDR_W'(T + 2)) DO = 8'(ndis_q);
        if (ADDR == ADDR_W'(E))     DO = eper_q[7:0];
        if (ADDR == ADDR_W'(E + 1)) DO = eper_q[15:8];
        if (ADDR == ADDR_W'(E + 2)) DO = {4'h0, shape_q};
    end
`else
    assign DO = 8'hFF;
`endif

endmodule
